// File: rtl/divmul_pkg.sv
// Shared types for the 16/8 divider and its reconstruction multiplier.
package divmul_pkg;
    localparam int W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] d;
        logic [W-1:0] r;
    } operand_t;
endpackage

// File: rtl/shift_add_step.sv
// One radix-2 shift-add step: conditional add, then shift both operands.
module shift_add_step #(
    parameter int W = 8
) (
    input  logic [2*W-1:0] acc,
    input  logic [2*W-1:0] mcand,
    input  logic [W-1:0]   mplier,
    output logic [2*W-1:0] acc_nxt,
    output logic [2*W-1:0] mcand_nxt,
    output logic [W-1:0]   mplier_nxt
);
    // Max result fits 2W bits, so the carry-out is dropped.
    assign acc_nxt    = mplier[0] ? acc + mcand : acc;
    assign mcand_nxt  = mcand << 1;
    assign mplier_nxt = mplier >> 1;
endmodule

// File: rtl/divider_inverse_mul_seq.sv
// Rebuilds the dividend n = q*d + r from a divider result, one bit per cycle.
module divider_inverse_mul_seq
    import divmul_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   q,
    input  logic [W-1:0]   d,
    input  logic [W-1:0]   r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] n,
    output logic           err
);
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*W-1:0]     acc;
    logic [2*W-1:0]     mcand;
    logic [W-1:0]       mplier;
    logic               err_r;

    logic [2*W-1:0]     acc_nxt;
    logic [2*W-1:0]     mcand_nxt;
    logic [W-1:0]       mplier_nxt;

    shift_add_step #(.W(W)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            err_r     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            n         <= '0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc      <= {{W{1'b0}}, r};
                        mcand    <= {{W{1'b0}}, d};
                        mplier   <= q;
                        err_r    <= (d == '0) || (r >= d);
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    // Always W steps, even once the multiplier runs out of ones.
                    acc    <= acc_nxt;
                    mcand  <= mcand_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(W - 1)) begin
                        n         <= acc_nxt;
                        err       <= err_r;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divider_inverse_mul_seq.sv
// Randomized scoreboard bench for the reconstruction multiplier.
module tb_divider_inverse_mul_seq;
    import divmul_pkg::*;

    typedef struct packed {
        logic [15:0] n;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  q = '0;
    logic [7:0]  d = '0;
    logic [7:0]  r = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] n;
    logic        err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   bp_en = 1'b0;

    divider_inverse_mul_seq #(.W(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .d         (d),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n         (n),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, req);
        end
    endtask

    // Reference: a legal division result reconstructs by plain arithmetic.
    function automatic exp_t model(input operand_t o);
        exp_t        e;
        int unsigned p;
        p     = int'(o.q) * int'(o.d) + int'(o.r);
        e.n   = p[15:0];
        e.err = (o.d == 8'd0) || (o.r >= o.d);
        return e;
    endfunction

    task automatic issue(input logic [7:0] qi, input logic [7:0] di,
                         input logic [7:0] ri, input exp_t e);
        int k;
        @(negedge clk);
        q = qi;
        d = di;
        r = ri;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout got in_ready=0 want 1");
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic exp_t mk(input logic [7:0] qi, input logic [7:0] di,
                                input logic [7:0] ri);
        operand_t o;
        o.q = qi;
        o.d = di;
        o.r = ri;
        return model(o);
    endfunction

    // Monitor: pops the scoreboard on each handshake, checks hold while stalled.
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [15:0] pn = '0;
    logic        pe = 1'b0;
    exp_t        me;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (pv && !pr) begin
                chk("hold_n", 32'(n), 32'(pn));
                chk("hold_err", 32'(err), 32'(pe));
            end
            chk("in_ready_done", 32'(in_ready), 32'd0);
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out got n=%0h want none", n);
                end else begin
                    me = sb.pop_front();
                    chk("n", 32'(n), 32'(me.n));
                    chk("err", 32'(err), 32'(me.err));
                end
            end
        end
        pv <= out_valid;
        pr <= out_ready;
        pn <= n;
        pe <= err;
    end

    initial begin
        exp_t e2;
        int   lat;
        int   k;
        int   dd;
        int   nn;

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_n", 32'(n), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("in_ready_pre_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("in_ready_post_edge", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Directed cases with latency measurement on the first one.
        issue(8'h0F, 8'h11, 8'h05, mk(8'h0F, 8'h11, 8'h05));
        chk("model_t1", 32'(sb[0].n), 32'h0104);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        chk("latency", 32'(lat), 32'd9);
        drain();

        issue(8'hFF, 8'hFF, 8'hFE, '{n: 16'hFEFF, err: 1'b0});
        issue(8'h07, 8'h00, 8'h03, '{n: 16'h0003, err: 1'b1});
        issue(8'h10, 8'h05, 8'h05, '{n: 16'h0055, err: 1'b1});
        issue(8'h00, 8'h09, 8'h04, '{n: 16'h0004, err: 1'b0});
        drain();

        // Back-pressure in DONE with a pending operand set.
        out_ready = 1'b0;
        issue(8'h21, 8'h03, 8'h02, '{n: 16'h0065, err: 1'b0});
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("bp_reach_done", 32'(out_valid), 32'd1);
        e2 = '{n: 16'h000D, err: 1'b0};
        q = 8'h03;
        d = 8'h04;
        r = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_n", 32'(n), 32'h0065);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        sb.push_back(e2);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_accepted", 32'(in_ready), 32'd0);
        drain();

        // Reset during the third BUSY cycle aborts silently.
        issue(8'h09, 8'h09, 8'h01, mk(8'h09, 8'h09, 8'h01));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_n", 32'(n), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("abort_in_ready_back", 32'(in_ready), 32'd1);
        issue(8'h02, 8'h03, 8'h01, '{n: 16'h0007, err: 1'b0});
        drain();

        // Random divider outputs: n must return the original dividend.
        bp_en = 1'b1;
        fork
            begin
                while (bp_en) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 1500; i++) begin
            dd = int'($urandom_range(1, 255));
            nn = int'($urandom_range(0, dd * 256 - 1));
            issue(8'(nn / dd), 8'(dd), 8'(nn % dd),
                  '{n: 16'(nn), err: 1'b0});
        end
        bp_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
